// File: rtl/conv2_pool_if.sv
// Row-in / pooled-row-out bundle for conv2_pool.
// master drives activated rows; slave is the pooling stage.
interface conv2_pool_if #(
  parameter int COLS = 12,
  parameter int DW   = 8
);
  logic                     din_valid;
  logic [COLS*DW-1:0]       din;
  logic [2:0]               ch_in;
  logic [(COLS/2)*DW-1:0]   dout;
  logic                     dout_valid;
  logic [2:0]               dout_ch;
  logic [2:0]               dout_row;
  logic                     frame_end;

  modport master (
    output din_valid, din, ch_in,
    input  dout, dout_valid, dout_ch, dout_row, frame_end
  );

  modport slave (
    input  din_valid, din, ch_in,
    output dout, dout_valid, dout_ch, dout_row, frame_end
  );
endinterface

// File: rtl/conv2_pool.sv
// 2x2 stride-2 pooling after layer-2 conv/activation.
// Max pooling by default; define CONV2_POOL_AVG_EN for average pooling.
module conv2_pool #(
  parameter int COLS = 12,
  parameter int ROWS = 12,
  parameter int DW   = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  conv2_pool_if.slave  bus
);

  localparam int NP = COLS / 2;
`ifdef CONV2_POOL_AVG_EN
  localparam int HW = DW + 1;
`else
  localparam int HW = DW;
`endif
  localparam logic [2:0] LAST = 3'(ROWS / 2 - 1);

  typedef enum logic {EVEN, ODD} state_t;

  state_t            state_q, state_d;
  logic              load, fire;
  logic [NP*HW-1:0]  h, hbuf;
  logic [NP*DW-1:0]  o;
  logic [2:0]        ch_lat, pair_cnt;

  for (genvar j = 0; j < NP; j++) begin : g_pix
    logic [DW-1:0] a, b;
    logic [HW-1:0] hb, hn;
    assign a  = bus.din[(COLS-2*j)*DW-1 -: DW];
    assign b  = bus.din[(COLS-2*j-1)*DW-1 -: DW];
    assign hb = hbuf[(NP-j)*HW-1 -: HW];
    assign hn = h[(NP-j)*HW-1 -: HW];
`ifdef CONV2_POOL_AVG_EN
    logic [DW+1:0] s;
    assign h[(NP-j)*HW-1 -: HW] = {1'b0, a} + {1'b0, b};
    assign s = {1'b0, hb} + {1'b0, hn};
    assign o[(NP-j)*DW-1 -: DW] = DW'(s >> 2);
`else
    assign h[(NP-j)*HW-1 -: HW] = (a > b) ? a : b;
    assign o[(NP-j)*DW-1 -: DW] = (hb > hn) ? hb : hn;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= EVEN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    fire    = 1'b0;
    if (clr) begin
      state_d = EVEN;
    end else if (bus.din_valid) begin
      unique case (state_q)
        EVEN: begin
          load    = 1'b1;
          state_d = ODD;
        end
        ODD: begin
          fire    = 1'b1;
          state_d = EVEN;
        end
        default: state_d = EVEN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hbuf           <= '0;
      ch_lat         <= '0;
      pair_cnt       <= '0;
      bus.dout       <= '0;
      bus.dout_valid <= 1'b0;
      bus.dout_ch    <= '0;
      bus.dout_row   <= '0;
      bus.frame_end  <= 1'b0;
    end else begin
      bus.dout_valid <= fire;
      bus.frame_end  <= fire && (pair_cnt == LAST);
      if (clr) pair_cnt <= '0;
      if (load) begin
        hbuf   <= h;
        ch_lat <= bus.ch_in;
      end
      if (fire) begin
        bus.dout     <= o;
        bus.dout_ch  <= ch_lat;
        bus.dout_row <= pair_cnt;
        pair_cnt     <= (pair_cnt == LAST) ? 3'd0 : pair_cnt + 3'd1;
      end
    end
  end

endmodule
